// File: rtl/cpu_pkg.sv
// Shared types and constants for the data-memory access sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int DEF_TIMEOUT = 64;
    // Timeout counter width: covers the full legal TIMEOUT range 2..255.
    localparam int TMO_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // A memory access is requested only while the core is running.
    function automatic logic is_access(input logic start, input logic rd, input logic wr);
        return start & (rd | wr);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count reflects an increment one cycle after inc_i.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    // Count enabled cycles, sticking at the maximum value.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && !(&cnt_o)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Turns EX/MEM MemRead/MemWrite into a req/ack access and freezes the pipeline meanwhile.
// Latency: request issued the cycle after the access is seen; DONE one cycle after ack (min 2 stall cycles).
// Backpressure: stall_o freezes all pipeline registers until the access completes or times out.
module dmem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             MemRead_i,
    input  logic             MemWrite_i,
    input  logic [XLEN-1:0]  addr_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic             mem_ack_i,
    input  logic [XLEN-1:0]  mem_rdata_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [XLEN-1:0]  mem_addr_o,
    output logic [XLEN-1:0]  mem_wdata_o,
    output logic             stall_o,
    output logic [XLEN-1:0]  rdata_o,
    output logic             rdata_valid_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // Last WAIT-cycle count value before the access is abandoned.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             access;
    logic             issue;
    logic             ack_hit;
    logic             tmo_hit;

    assign access = is_access(start_i, MemRead_i, MemWrite_i);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, stall and the per-cycle events that drive the datapath.
    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        issue     = 1'b0;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                stall_o = access;
                if (access) begin
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                // A late ack in the final counted cycle still wins over the timeout.
                if (mem_ack_i) begin
                    ack_hit   = 1'b1;
                    state_nxt = DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Pipeline advances this cycle, so the finished access is never re-seen.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory request registers, returned data, timeout counter and error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            if (issue) begin
                // Simultaneous read and write resolves to a write.
                mem_req_o   <= 1'b1;
                mem_we_o    <= MemWrite_i;
                mem_addr_o  <= addr_i;
                mem_wdata_o <= wdata_i;
                tmo_cnt     <= '0;
            end
            if (ack_hit) begin
                mem_req_o <= 1'b0;
                if (!mem_we_o) begin
                    rdata_o       <= mem_rdata_i;
                    rdata_valid_o <= 1'b1;
                end
            end else if (tmo_hit) begin
                mem_req_o <= 1'b0;
                err_o     <= 1'b1;
                if (!mem_we_o) begin
                    rdata_o       <= '0;
                    rdata_valid_o <= 1'b1;
                end
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (state == DONE) begin
                rdata_valid_o <= 1'b0;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (stall_o),
        .cnt_o (stall_cnt_o)
    );

endmodule
